led_controller: RTL and testbench

- DMA LED controller: the read-side counterpart of the button DMA writer.
- On copy_start it reads LED_COUNT consecutive words from data memory starting at LED_ADDR into a shadow register file, then commits all of them at once into active brightness registers.
- Each LED output is driven by a free-running PWM comparator against its committed brightness.
- Sits on the data-memory read port, which the top level grants to it while copy is in progress.

---
 rtl/led_controller.sv | 127 ++++++++++++
 tb/tb_led_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/led_controller.sv
// DMA LED controller: copies LED_COUNT brightness words from data memory into a
// shadow file, commits them atomically, and drives one PWM output per LED.
module led_controller #(
  parameter int          LED_COUNT  = 8,
  parameter logic [15:0] LED_ADDR   = 16'h1F00,
  parameter int          ADDR_WIDTH = 13,
  parameter int          PWM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  copy_start,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_din_addr,
  input  logic [15:0]           mem_din,
  output logic                  busy,
  output logic                  done,
  output logic [LED_COUNT-1:0]  led_out
);

  localparam int IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = LED_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] LAST = BASE + ADDR_WIDTH'(LED_COUNT - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [IDX_W-1:0]      rd_idx, rd_idx_nxt;
  logic                  commit;

  logic                  vld_p0;
  logic [IDX_W-1:0]      idx_p0;

  logic [PWM_WIDTH-1:0]  din_w;
  logic                  unused_din;
  logic [PWM_WIDTH-1:0]  shadow [LED_COUNT];
  logic [PWM_WIDTH-1:0]  active [LED_COUNT];
  logic [PWM_WIDTH-1:0]  cnt;

  assign din_w        = mem_din[PWM_WIDTH-1:0];
  assign unused_din   = ^mem_din[15:PWM_WIDTH];
  assign mem_din_addr = addr;
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    rd_idx_nxt = rd_idx;
    mem_re     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (copy_start) begin
          state_nxt  = READ;
          addr_nxt   = BASE;
          rd_idx_nxt = '0;
        end
      end
      READ: begin
        mem_re = 1'b1;
        if (addr == LAST) begin
          state_nxt = DRAIN;
        end else begin
          addr_nxt   = addr + ADDR_WIDTH'(1);
          rd_idx_nxt = rd_idx + IDX_W'(1);
        end
      end
      DRAIN: begin
        commit     = 1'b1;
        state_nxt  = IDLE;
        addr_nxt   = BASE;
        rd_idx_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr   <= BASE;
      rd_idx <= '0;
      vld_p0 <= 1'b0;
      idx_p0 <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      rd_idx <= rd_idx_nxt;
      vld_p0 <= mem_re;
      idx_p0 <= rd_idx;
      done   <= commit;
    end
  end

  // p0 -> capture: read data arrives one cycle after its address.
  // The last word is bypassed straight into the commit so every LED switches on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < LED_COUNT; j++) begin
        shadow[j] <= '0;
        active[j] <= '0;
      end
    end else begin
      if (vld_p0) shadow[idx_p0] <= din_w;
      if (commit) begin
        for (int j = 0; j < LED_COUNT; j++) begin
          active[j] <= (vld_p0 && (idx_p0 == IDX_W'(j))) ? din_w : shadow[j];
        end
      end
    end
  end

  // PWM stage: free-running counter; never restarted by a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      led_out <= '0;
    end else begin
      cnt <= cnt + PWM_WIDTH'(1);
      for (int i = 0; i < LED_COUNT; i++) begin
        led_out[LED_COUNT-1-i] <= (cnt < active[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_controller.sv
// Directed bench for led_controller: address scoreboard, control timing, PWM duty,
// atomic commit, back-to-back copies and reset mid-copy.
module tb_led_controller;

  localparam logic [12:0] BASE = 13'h1F00;
  localparam logic [63:0] OLD_ACT = 64'h00FF8040011020C0;

  logic        clk;
  logic        reset;
  logic        copy_start;
  logic        mem_re;
  logic [12:0] mem_din_addr;
  logic [15:0] mem_din;
  logic        busy;
  logic        done;
  logic [7:0]  led_out;

  logic [15:0] mem [8];
  logic [12:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;

  led_controller dut (
    .clk          (clk),
    .reset        (reset),
    .copy_start   (copy_start),
    .mem_re       (mem_re),
    .mem_din_addr (mem_din_addr),
    .mem_din      (mem_din),
    .busy         (busy),
    .done         (done),
    .led_out      (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle synchronous RAM model
  always @(posedge clk) begin
    if (mem_re) mem_din <= mem[mem_din_addr[2:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Address scoreboard: every read must match the next expected address.
  always @(negedge clk) begin
    if (mem_re === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL addr_unexpected obs=%0h exp=none", mem_din_addr);
      end else begin
        chk("addr", {51'd0, mem_din_addr}, {51'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [63:0] act_pack();
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[55:0], dut.active[i]};
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_addrs();
    for (int i = 0; i < 8; i++) exp_q.push_back(BASE + 13'(i));
  endtask

  initial begin
    int hi [8];
    int exp_duty [8];
    exp_duty = '{192, 32, 16, 1, 64, 128, 255, 0};
    reset = 1'b1;
    copy_start = 1'b0;
    mem_din = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      chk("rst_led", {56'd0, led_out}, 64'd0);
      chk("rst_mem_re", {63'd0, mem_re}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_addr", {51'd0, mem_din_addr}, {51'd0, BASE});
    end

    // single copy
    mem = '{16'h0000, 16'h00FF, 16'h0080, 16'h0040, 16'h0001, 16'hFF10, 16'h0020, 16'h00C0};
    copy_start = 1'b1;
    push_addrs();
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) copy_start = 1'b0;
      chk("single_mem_re", {63'd0, mem_re}, {63'd0, (k <= 8)});
      chk("single_busy", {63'd0, busy}, {63'd0, (k <= 9)});
      chk("single_done", {63'd0, done}, {63'd0, (k == 10)});
      if (k == 10) chk("single_idle_addr", {51'd0, mem_din_addr}, {51'd0, BASE});
    end

    // PWM duty over one full counter period
    tick();
    tick();
    for (int b = 0; b < 8; b++) hi[b] = 0;
    for (int c = 0; c < 256; c++) begin
      tick();
      for (int b = 0; b < 8; b++) if (led_out[b]) hi[b]++;
    end
    for (int b = 0; b < 8; b++) chk($sformatf("duty%0d", b), 64'(hi[b]), 64'(exp_duty[b]));

    // atomic commit
    for (int i = 0; i < 8; i++) mem[i] = 16'h0010;
    chk("atomic_before", act_pack(), OLD_ACT);
    copy_start = 1'b1;
    push_addrs();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) copy_start = 1'b0;
      chk($sformatf("atomic_c%0d", k), act_pack(), (k <= 9) ? OLD_ACT : 64'h1010101010101010);
    end

    // copy_start held high: back-to-back transfers with one IDLE gap
    for (int i = 0; i < 8; i++) mem[i] = 16'h0011 * 16'(i + 1);
    tick();
    copy_start = 1'b1;
    push_addrs();
    push_addrs();
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk($sformatf("held_mem_re_c%0d", k), {63'd0, mem_re},
          {63'd0, ((k >= 1 && k <= 8) || (k >= 11 && k <= 18))});
      chk($sformatf("held_busy_c%0d", k), {63'd0, busy}, {63'd0, ((k <= 9) || (k >= 11 && k <= 19))});
      chk($sformatf("held_done_c%0d", k), {63'd0, done}, {63'd0, (k == 10 || k == 20)});
      if (k == 10) chk("held_active", act_pack(), 64'h1122334455667788);
      if (k == 11) copy_start = 1'b0;
    end
    chk("held_q_empty", 64'(exp_q.size()), 64'd0);

    // reset in cycle 4 of a copy
    for (int i = 0; i < 8; i++) mem[i] = 16'h0100 + 16'h0010 * 16'(i);
    tick();
    copy_start = 1'b1;
    push_addrs();
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) copy_start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_mem_re", {63'd0, mem_re}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_led", {56'd0, led_out}, 64'd0);
    chk("abort_active", act_pack(), 64'd0);
    chk("abort_state", {62'd0, dut.state}, 64'd0);
    for (int k = 6; k <= 12; k++) begin
      tick();
      chk($sformatf("abort_no_done_c%0d", k), {63'd0, done}, 64'd0);
      chk($sformatf("abort_led_c%0d", k), {56'd0, led_out}, 64'd0);
    end
    exp_q.delete();

    // full copy after the abort
    copy_start = 1'b1;
    push_addrs();
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) copy_start = 1'b0;
      chk($sformatf("recover_done_c%0d", k), {63'd0, done}, {63'd0, (k == 10)});
    end
    chk("recover_active", act_pack(), 64'h0010203040506070);
    chk("recover_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
